// File: rtl/nfc_atomic_ca_latch.sv
// Command/address latch responder: drives the NAND CE#/CLE/ALE/WE#/DQ byte sequence.
// Optional trailing CE#-low postamble enabled by defining NFC_CA_POSTAMBLE_EN.
module nfc_atomic_ca_latch #(
  parameter int unsigned NumberOfWays = 4,
  parameter int unsigned CommandBit   = 6,
  parameter int unsigned SetupCycles  = 2,
  parameter int unsigned WeLowCycles  = 2,
  parameter int unsigned WeHighCycles = 2,
  parameter int unsigned PostCycles   = 4
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [7:0]              iCommand,
  input  logic [NumberOfWays-1:0] iTargetWay,
  input  logic                    iCASelect,
  input  logic [39:0]             iCAData,
  input  logic [15:0]             iNumOfData,
  output logic                    oReady,
  output logic                    oLastStep,
  output logic [NumberOfWays-1:0] oPO_CE,
  output logic                    oPO_CLE,
  output logic                    oPO_ALE,
  output logic                    oPO_WE,
  output logic [7:0]              oPO_DQ,
  output logic                    oPO_DQ_OE
);

  localparam int unsigned MaxSL     = (SetupCycles > WeLowCycles) ? SetupCycles : WeLowCycles;
  localparam int unsigned MaxHP     = (WeHighCycles > PostCycles) ? WeHighCycles : PostCycles;
  localparam int unsigned MaxCycles = (MaxSL > MaxHP) ? MaxSL : MaxHP;
  localparam int unsigned PhaseW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WE_LOW, S_WE_HIGH, S_POST, S_DONE
  } state_t;

  state_t                  r_state, w_state;
  logic [PhaseW-1:0]       r_phase, w_phase;
  logic [39:0]             r_shift, w_shift;
  logic [2:0]              r_bytes, w_bytes;
  logic [NumberOfWays-1:0] r_way, w_way;
  logic                    r_sel, w_sel;

  logic                    r_ready, w_ready;
  logic                    r_last, w_last;
  logic [NumberOfWays-1:0] r_ce, w_ce;
  logic                    r_cle, w_cle;
  logic                    r_ale, w_ale;
  logic                    r_we, w_we;
  logic [7:0]              r_dq, w_dq;
  logic                    r_oe, w_oe;

  logic                    w_start;
  logic [2:0]              w_count;
  logic                    w_unused_cmd;

  // Only one command bit is decoded; the rest belong to sibling channels.
  assign w_unused_cmd = ^iCommand;
  assign w_start      = iCommand[CommandBit] & r_ready;
  assign w_count      = (iNumOfData > 16'd5) ? 3'd5 : iNumOfData[2:0];

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_shift <= '0;
      r_bytes <= '0;
      r_way   <= '1;
      r_sel   <= 1'b0;
      r_ready <= 1'b1;
      r_last  <= 1'b0;
      r_ce    <= '1;
      r_cle   <= 1'b0;
      r_ale   <= 1'b0;
      r_we    <= 1'b1;
      r_dq    <= 8'h00;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_shift <= w_shift;
      r_bytes <= w_bytes;
      r_way   <= w_way;
      r_sel   <= w_sel;
      r_ready <= w_ready;
      r_last  <= w_last;
      r_ce    <= w_ce;
      r_cle   <= w_cle;
      r_ale   <= w_ale;
      r_we    <= w_we;
      r_dq    <= w_dq;
      r_oe    <= w_oe;
    end
  end

  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_shift = r_shift;
    w_bytes = r_bytes;
    w_way   = r_way;
    w_sel   = r_sel;
    w_ready = 1'b0;
    w_last  = 1'b0;
    w_ce    = '1;
    w_cle   = 1'b0;
    w_ale   = 1'b0;
    w_we    = 1'b1;
    w_dq    = 8'h00;
    w_oe    = 1'b0;

    // Next state; DONE accepts a new start exactly like IDLE.
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state = S_IDLE;
        if (w_start) begin
          w_way   = iTargetWay;
          w_sel   = iCASelect;
          w_shift = iCAData;
          w_bytes = w_count;
          if (w_count == 3'd0) begin
            w_state = S_DONE;
          end else begin
            w_state = S_SETUP;
            w_phase = PhaseW'(SetupCycles - 1);
          end
        end
      end
      S_SETUP: begin
        if (r_phase == '0) begin
          w_state = S_WE_LOW;
          w_phase = PhaseW'(WeLowCycles - 1);
        end else begin
          w_phase = r_phase - PhaseW'(1);
        end
      end
      S_WE_LOW: begin
        if (r_phase == '0) begin
          w_state = S_WE_HIGH;
          w_phase = PhaseW'(WeHighCycles - 1);
        end else begin
          w_phase = r_phase - PhaseW'(1);
        end
      end
      S_WE_HIGH: begin
        if (r_phase == '0) begin
          w_shift = {r_shift[31:0], 8'h00};
          w_bytes = r_bytes - 3'd1;
          if (r_bytes > 3'd1) begin
            w_state = S_SETUP;
            w_phase = PhaseW'(SetupCycles - 1);
          end else begin
`ifdef NFC_CA_POSTAMBLE_EN
            w_state = S_POST;
            w_phase = PhaseW'(PostCycles - 1);
`else
            w_state = S_DONE;
`endif
          end
        end else begin
          w_phase = r_phase - PhaseW'(1);
        end
      end
      S_POST: begin
        if (r_phase == '0) begin
          w_state = S_DONE;
        end else begin
          w_phase = r_phase - PhaseW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Pin values decoded from the state being entered, so every output is registered.
    case (w_state)
      S_IDLE: w_ready = 1'b1;
      S_SETUP, S_WE_LOW, S_WE_HIGH: begin
        w_ce  = w_way;
        w_cle = w_sel;
        w_ale = ~w_sel;
        w_dq  = w_shift[39:32];
        w_oe  = 1'b1;
        w_we  = (w_state != S_WE_LOW);
      end
      S_POST: w_ce = w_way;
      S_DONE: begin
        w_ce    = w_way;
        w_ready = 1'b1;
        w_last  = 1'b1;
      end
      default: w_ready = 1'b1;
    endcase
  end

  assign oReady    = r_ready;
  assign oLastStep = r_last;
  assign oPO_CE    = r_ce;
  assign oPO_CLE   = r_cle;
  assign oPO_ALE   = r_ale;
  assign oPO_WE    = r_we;
  assign oPO_DQ    = r_dq;
  assign oPO_DQ_OE = r_oe;

endmodule

// File: tb/tb_nfc_atomic_ca_latch.sv
// Directed self-checking bench for nfc_atomic_ca_latch (default parameters).
module tb_nfc_atomic_ca_latch;

`ifdef NFC_CA_POSTAMBLE_EN
  localparam int Post = 4;
`else
  localparam int Post = 0;
`endif

  logic        iSystemClock = 1'b0;
  logic        iReset;
  logic [7:0]  iCommand;
  logic [3:0]  iTargetWay;
  logic        iCASelect;
  logic [39:0] iCAData;
  logic [15:0] iNumOfData;
  logic        oReady, oLastStep, oPO_CLE, oPO_ALE, oPO_WE, oPO_DQ_OE;
  logic [3:0]  oPO_CE;
  logic [7:0]  oPO_DQ;

  nfc_atomic_ca_latch dut (
    .iSystemClock(iSystemClock), .iReset(iReset), .iCommand(iCommand),
    .iTargetWay(iTargetWay), .iCASelect(iCASelect), .iCAData(iCAData),
    .iNumOfData(iNumOfData), .oReady(oReady), .oLastStep(oLastStep),
    .oPO_CE(oPO_CE), .oPO_CLE(oPO_CLE), .oPO_ALE(oPO_ALE), .oPO_WE(oPO_WE),
    .oPO_DQ(oPO_DQ), .oPO_DQ_OE(oPO_DQ_OE)
  );

  always #5 iSystemClock = ~iSystemClock;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int          last_cyc, pulses, low_w, inject_cyc;
  logic [39:0] bytes_rx;
  logic [3:0]  ce_f;
  logic        cle_f, ale_f;
  logic [17:0] reset_vec;
  logic        quiet;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] outv();
    return {oReady, oLastStep, oPO_CE, oPO_CLE, oPO_ALE, oPO_WE, oPO_DQ, oPO_DQ_OE};
  endfunction

  // Waits one idle cycle, then presents a start for one cycle.
  task automatic start(input logic [3:0] way, input logic sel, input logic [39:0] data,
                       input logic [15:0] num);
    @(posedge iSystemClock); #1;
    iTargetWay = way;
    iCASelect  = sel;
    iCAData    = data;
    iNumOfData = num;
    iCommand   = 8'h40;
  endtask

  // Observes pins cycle by cycle until LastStep, bounded at 60 cycles.
  task automatic capture();
    int   cur_low;
    logic prev_we;
    last_cyc = 0; pulses = 0; low_w = 0; bytes_rx = '0; cur_low = 0;
    ce_f = 4'hF; cle_f = 1'b0; ale_f = 1'b0;
    prev_we = oPO_WE;
    for (int k = 1; k <= 60; k++) begin
      @(posedge iSystemClock); #1;
      iCommand = 8'h00;
      if (k == inject_cyc) begin
        iCommand   = 8'h40;
        iTargetWay = 4'b0111;
        iCAData    = 40'h11_2233_4455;
        iNumOfData = 16'd3;
      end
      if (!oPO_WE) begin
        cur_low++;
        if (prev_we) begin
          pulses++;
          bytes_rx = {bytes_rx[31:0], oPO_DQ};
          if (pulses == 1) begin
            ce_f = oPO_CE; cle_f = oPO_CLE; ale_f = oPO_ALE;
          end
        end
      end else if (!prev_we) begin
        low_w   = cur_low;
        cur_low = 0;
      end
      prev_we = oPO_WE;
      if (oLastStep) begin
        last_cyc = k;
        break;
      end
    end
    iCommand = 8'h00;
  endtask

  initial begin
    reset_vec  = {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    inject_cyc = 0;
    iReset = 1'b1; iCommand = 8'h00; iTargetWay = 4'hF; iCASelect = 1'b0;
    iCAData = '0; iNumOfData = '0;
    repeat (3) @(posedge iSystemClock);
    #1 iReset = 1'b0;
    @(posedge iSystemClock); #1;
    check("reset_state", 64'(outv()), 64'(reset_vec));

    // Single command byte
    start(4'b1110, 1'b1, 40'hFF_0000_0000, 16'd1);
    capture();
    check("s1_laststep", 64'(last_cyc), 64'(7 + Post));
    check("s1_pulses", 64'(pulses), 64'd1);
    check("s1_dq", 64'(bytes_rx[7:0]), 64'hFF);
    check("s1_we_low_width", 64'(low_w), 64'd2);
    check("s1_ce", 64'(ce_f), 64'(4'b1110));
    check("s1_cle", 64'(cle_f), 64'd1);
    check("s1_ale", 64'(ale_f), 64'd0);
    @(posedge iSystemClock); #1;
    check("s1_back_idle", 64'({oPO_CE, oReady, oLastStep}), 64'({4'hF, 1'b1, 1'b0}));

    // Five address bytes
    start(4'b1101, 1'b0, 40'h01_0203_0405, 16'd5);
    capture();
    check("s2_laststep", 64'(last_cyc), 64'(31 + Post));
    check("s2_pulses", 64'(pulses), 64'd5);
    check("s2_bytes", 64'(bytes_rx), 64'h01_0203_0405);
    check("s2_ale", 64'(ale_f), 64'd1);
    check("s2_cle", 64'(cle_f), 64'd0);
    check("s2_ce", 64'(ce_f), 64'(4'b1101));

    // Zero count and over-range count
    start(4'b1011, 1'b1, 40'hAA_0000_0000, 16'd0);
    capture();
    check("s3_zero_laststep", 64'(last_cyc), 64'd1);
    check("s3_zero_pulses", 64'(pulses), 64'd0);
    start(4'b0111, 1'b0, 40'hA1_B2C3_D4E5, 16'd9);
    capture();
    check("s3_clamp_pulses", 64'(pulses), 64'd5);
    check("s3_clamp_bytes", 64'(bytes_rx), 64'hA1_B2C3_D4E5);
    check("s3_clamp_laststep", 64'(last_cyc), 64'(31 + Post));

    // Start while busy is ignored
    inject_cyc = 3;
    start(4'b1110, 1'b1, 40'hFF_0000_0000, 16'd1);
    capture();
    inject_cyc = 0;
    check("s4_busy_pulses", 64'(pulses), 64'd1);
    check("s4_busy_dq", 64'(bytes_rx[7:0]), 64'hFF);
    check("s4_busy_ce", 64'(ce_f), 64'(4'b1110));
    check("s4_busy_laststep", 64'(last_cyc), 64'(7 + Post));
    // Foreign command bit while idle
    @(posedge iSystemClock); #1;
    iCommand = 8'h08;
    quiet = 1'b1;
    repeat (6) begin
      @(posedge iSystemClock); #1;
      if (!(oPO_CE == 4'hF && oPO_WE && !oPO_DQ_OE && oReady && !oLastStep)) quiet = 1'b0;
    end
    iCommand = 8'h00;
    check("s4_bit3_ignored", 64'(quiet), 64'd1);

    // Back-to-back start accepted in the DONE cycle
    start(4'b1110, 1'b1, 40'h00_0000_0000, 16'd0);
    @(posedge iSystemClock); #1;
    check("b2b_done", 64'({oLastStep, oReady, oPO_CE}), 64'({1'b1, 1'b1, 4'b1110}));
    iCAData    = 40'h5A_0000_0000;
    iNumOfData = 16'd1;
    @(posedge iSystemClock); #1;
    iCommand = 8'h00;
    check("b2b_setup", 64'({oReady, oPO_CE, oPO_CLE, oPO_DQ, oPO_DQ_OE, oPO_WE}),
          64'({1'b0, 4'b1110, 1'b1, 8'h5A, 1'b1, 1'b1}));
    capture();
    check("b2b_laststep", 64'(last_cyc), 64'(6 + Post));
    check("b2b_dq", 64'({pulses[3:0], bytes_rx[7:0]}), 64'({4'd1, 8'h5A}));

    // Reset during the third WE# low
    start(4'b1101, 1'b0, 40'h01_0203_0405, 16'd5);
    for (int k = 1; k <= 15; k++) begin
      @(posedge iSystemClock); #1;
      iCommand = 8'h00;
    end
    check("s5_in_we_low", 64'({oPO_WE, oPO_DQ}), 64'({1'b0, 8'h03}));
    iReset = 1'b1;
    @(posedge iSystemClock); #1;
    iReset = 1'b0;
    check("s5_reset_outputs", 64'(outv()), 64'(reset_vec));
    quiet = 1'b1;
    repeat (10) begin
      @(posedge iSystemClock); #1;
      if (oLastStep || oPO_CE != 4'hF || !oReady) quiet = 1'b0;
    end
    check("s5_no_laststep", 64'(quiet), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
